// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: address width, state encodings and vector defaults.
package pc_sequencer_pkg;

    localparam int unsigned IM_ADDR_BIT    = 16;
    localparam int unsigned PCS_VEC_BASE   = 32'h100;
    localparam int unsigned PCS_VEC_STRIDE = 4;

    typedef enum logic {
        PCS_RUN  = 1'b0,
        PCS_HALT = 1'b1
    } pcs_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_sequencer_irq_prio_enc.sv
// Lowest-index-wins priority encoder for the pending interrupt lines.
module irq_prio_enc
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 3,
    parameter int unsigned IDX_W   = idx_width(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_IRQ-1:0] mask
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        mask  = '0;
        // Scan downward so the lowest set line is the last to overwrite.
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid   = 1'b1;
                idx     = IDX_W'(i);
                mask    = '0;
                mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC redirect arbiter: halt, interrupt entry, eret, jump, branch, sequential fetch.
// Optional perf counters (cyc_cnt, stall_cnt) are enabled with PC_SEQ_PERF_CNT_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W     = IM_ADDR_BIT,
    parameter int unsigned NUM_IRQ    = 3,
    parameter int unsigned VEC_BASE   = PCS_VEC_BASE,
    parameter int unsigned VEC_STRIDE = PCS_VEC_STRIDE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] pc_4,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              eret,
    input  logic              halt_req,
    input  logic              resume,
    input  logic [NUM_IRQ-1:0] irq,
    output logic              pc_en,
    output logic              pc_ld,
    output logic [ADDR_W-1:0] pc_new,
    output logic [ADDR_W-1:0] epc,
    output logic              in_isr,
    output logic              halted,
    output logic [NUM_IRQ-1:0] irq_ack
`ifdef PC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int unsigned IDX_W = idx_width(NUM_IRQ);

    pcs_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [ADDR_W-1:0]  epc_q, epc_d;
    logic               in_isr_q, in_isr_d;
    logic [NUM_IRQ-1:0] ack_q, ack_d;

    logic               irq_valid;
    logic [IDX_W-1:0]   irq_idx;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               take;
    logic [ADDR_W-1:0]  vec_addr;
    logic [ADDR_W-1:0]  fall_addr;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_prio (
        .req   (pending_q),
        .valid (irq_valid),
        .idx   (irq_idx),
        .mask  (irq_mask)
    );

    assign take = (state_q == PCS_RUN) && !in_isr_q && !stall && !halt_req && irq_valid;

    // 32-bit arithmetic truncated to ADDR_W gives the required modular wrap.
    assign vec_addr  = ADDR_W'(VEC_BASE + 32'(irq_idx) * VEC_STRIDE);
    assign fall_addr = jmp ? jmp_target : (br_taken ? br_target : pc_4);

    always_comb begin
        state_d   = state_q;
        pending_d = (pending_q | irq) & ~(take ? irq_mask : '0);
        epc_d     = epc_q;
        in_isr_d  = in_isr_q;
        ack_d     = '0;
        pc_en     = 1'b1;
        pc_ld     = 1'b0;
        pc_new    = pc_4;
        if (state_q == PCS_HALT) begin
            pc_en = 1'b0;
            if (resume) state_d = PCS_RUN;
        end else if (stall) begin
            pc_en = 1'b0;
        end else if (halt_req) begin
            pc_en   = 1'b0;
            state_d = PCS_HALT;
        end else if (take) begin
            pc_ld    = 1'b1;
            pc_new   = vec_addr;
            epc_d    = fall_addr;
            in_isr_d = 1'b1;
            ack_d    = irq_mask;
        end else if (eret && in_isr_q) begin
            pc_ld    = 1'b1;
            pc_new   = epc_q;
            in_isr_d = 1'b0;
        end else if (jmp) begin
            pc_ld  = 1'b1;
            pc_new = jmp_target;
        end else if (br_taken) begin
            pc_ld  = 1'b1;
            pc_new = br_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PCS_RUN;
            pending_q <= '0;
            epc_q     <= '0;
            in_isr_q  <= 1'b0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            epc_q     <= epc_d;
            in_isr_q  <= in_isr_d;
            ack_q     <= ack_d;
        end
    end

    assign epc     = epc_q;
    assign in_isr  = in_isr_q;
    assign halted  = (state_q == PCS_HALT);
    assign irq_ack = ack_q;

`ifdef PC_SEQ_PERF_CNT_EN
    logic [31:0] cyc_q, stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            stall_q <= '0;
        end else if (state_q == PCS_RUN) begin
            cyc_q <= cyc_q + 32'd1;
            if (stall) stall_q <= stall_q + 32'd1;
        end
    end

    assign cyc_cnt   = cyc_q;
    assign stall_cnt = stall_q;
`endif

    // pc is part of the PC-register interface but no decision depends on it.
    logic unused_pc;
    assign unused_pc = ^pc;

endmodule
